// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//
// Boot loader that receives a program image as a byte stream, assembles
// little-endian 32-bit words and writes them into instruction memory. The
// core is held in reset until the whole image has been written.
//
// Stream format: 4-byte LE word count N, then N words of 4 bytes each, LE
// (first byte of a word lands in bits [7:0]).
//
// Optional feature, compile-time macro CHECKSUM_EN:
//   When defined, one extra byte follows the image. It must equal the 8-bit
//   wrap-around sum of all N*4 data bytes (header bytes excluded). A match
//   completes the load; a mismatch aborts it. N==0 also expects this byte,
//   with value 8'h00.
//   When undefined, the load completes right after the last word is written.
//
// Parameters:
//   ADDR_W     iMem word-address width
//   DEPTH      iMem capacity in words (must be <= 2**ADDR_W)
//   BASE_ADDR  word address of the first loaded word
//
// Ports:
//   clk         single clock, all logic on posedge
//   rst_n       synchronous reset, ACTIVE-HIGH (1 = reset)
//   byte_valid  byte_data is valid
//   byte_data   stream byte
//   byte_ready  loader accepts a byte this cycle
//   imem_we     iMem write strobe, one cycle per word
//   imem_addr   iMem word address (holds last written value)
//   imem_wdata  iMem write data (holds last written value)
//   core_rst    active-high core reset, released only on a completed load
//   load_done   image fully loaded (sticky until reset)
//   load_err    load aborted (sticky until reset)

module imem_boot_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              load_done,
  output logic              load_err
);

  // Wide enough to hold a word count of DEPTH itself.
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    S_HDR,
    S_DATA,
    S_WRITE,
`ifdef CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERROR
  } state_t;

  state_t             state;
  state_t             state_next;

  // Low for the first cycle after reset so byte_ready reads 0 right after
  // the reset edge, as every other output does.
  logic               armed;

  logic [1:0]         byte_idx;
  // Only the first three bytes of a word need storage; the fourth is
  // taken straight from byte_data when the word completes.
  logic [23:0]        byte_sr;
  logic [31:0]        word_full;
  logic               accept;
  logic               word_last;

  logic [CNT_W-1:0]   n_words;
  logic [CNT_W-1:0]   word_cnt;
  logic [CNT_W-1:0]   word_cnt_inc;
  logic [ADDR_W-1:0]  addr_next;

`ifdef CHECKSUM_EN
  logic [7:0]         csum;
`endif

  assign accept       = byte_valid && byte_ready;
  assign word_full    = {byte_data, byte_sr};
  assign word_last    = accept && (byte_idx == 2'd3);
  assign word_cnt_inc = word_cnt + CNT_W'(1);
  // word_cnt < n_words <= DEPTH whenever this is used, so the address
  // stays inside BASE_ADDR .. BASE_ADDR+DEPTH-1.
  assign addr_next    = ADDR_W'(BASE_ADDR) + ADDR_W'(word_cnt);

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= S_HDR;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state and state-decoded outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state;
    byte_ready = 1'b0;
    imem_we    = 1'b0;
    core_rst   = 1'b1;
    load_done  = 1'b0;
    load_err   = 1'b0;

    unique case (state)
      S_HDR: begin
        byte_ready = armed;
        if (word_last) begin
          if (word_full == 32'd0) begin
`ifdef CHECKSUM_EN
            state_next = S_CSUM;
`else
            state_next = S_DONE;
`endif
          end else if (word_full > 32'(DEPTH)) begin
            state_next = S_ERROR;
          end else begin
            state_next = S_DATA;
          end
        end
      end

      S_DATA: begin
        byte_ready = armed;
        if (word_last) begin
          state_next = S_WRITE;
        end
      end

      S_WRITE: begin
        imem_we = 1'b1;
        if (word_cnt_inc == n_words) begin
`ifdef CHECKSUM_EN
          state_next = S_CSUM;
`else
          state_next = S_DONE;
`endif
        end else begin
          state_next = S_DATA;
        end
      end

`ifdef CHECKSUM_EN
      S_CSUM: begin
        byte_ready = armed;
        if (accept) begin
          state_next = (byte_data == csum) ? S_DONE : S_ERROR;
        end
      end
`endif

      S_DONE: begin
        core_rst  = 1'b0;
        load_done = 1'b1;
      end

      S_ERROR: begin
        load_err = 1'b1;
      end

      default: begin
        state_next = S_ERROR;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath: byte assembly, counters, iMem address/data registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst_n) begin
      armed      <= 1'b0;
      byte_idx   <= '0;
      byte_sr    <= '0;
      n_words    <= '0;
      word_cnt   <= '0;
      imem_addr  <= ADDR_W'(BASE_ADDR);
      imem_wdata <= '0;
    end else begin
      armed <= 1'b1;

      if (accept && (state == S_HDR || state == S_DATA)) begin
        byte_idx <= byte_idx + 2'd1;
        byte_sr  <= {byte_data, byte_sr[23:8]};
      end

      // An oversize count is never used: that path goes to S_ERROR.
      if (word_last && state == S_HDR) begin
        n_words <= word_full[CNT_W-1:0];
      end

      // Address and data are registered on the 4th byte so they are
      // already stable during the single S_WRITE cycle.
      if (word_last && state == S_DATA) begin
        imem_addr  <= addr_next;
        imem_wdata <= word_full;
      end

      if (state == S_WRITE) begin
        word_cnt <= word_cnt_inc;
      end
    end
  end

`ifdef CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst_n) begin
      csum <= '0;
    end else if (accept && state == S_DATA) begin
      csum <= csum + byte_data;
    end
  end
`endif

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;

  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned DEPTH     = 1024;
  localparam int unsigned BASE_ADDR = 0;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_rst;
  logic              load_done;
  logic              load_err;

  always #5 clk = ~clk;

  imem_boot_loader #(
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE_ADDR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  typedef struct {
    logic              rst;
    logic              v;
    logic [7:0]        d;
    logic              rdy;
    logic              we;
    logic [ADDR_W-1:0] a;
    logic [31:0]       wd;
    logic              crst;
    logic              dn;
    logic              er;
  } vec_t;

  vec_t              tbl[$];
  int                n_vec  = 0;
  int                n_miss = 0;

  logic [ADDR_W-1:0] wl_addr[$];
  logic [31:0]       wl_data[$];
  logic [7:0]        img[12];
  logic [7:0]        img_sum;

  // Write log, sampled away from the active edge.
  always @(negedge clk) begin
    if (imem_we) begin
      wl_addr.push_back(imem_addr);
      wl_data.push_back(imem_wdata);
    end
  end

  function automatic void add(int rst, int v, int d, int rdy, int we, int a,
                              logic [31:0] wd, int crst, int dn, int er);
    vec_t r;
    r.rst  = (rst != 0);
    r.v    = (v != 0);
    r.d    = 8'(d);
    r.rdy  = (rdy != 0);
    r.we   = (we != 0);
    r.a    = ADDR_W'(a);
    r.wd   = wd;
    r.crst = (crst != 0);
    r.dn   = (dn != 0);
    r.er   = (er != 0);
    tbl.push_back(r);
  endfunction

  function automatic logic [63:0] obs();
    return 64'({byte_ready, imem_we, imem_addr, imem_wdata, core_rst, load_done, load_err});
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n      = 1'b1;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int   n;
    logic acc;
    n          = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    forever begin
      acc = byte_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > 20) begin
        n_vec++;
        n_miss++;
        $display("FAIL send_byte_timeout: byte %h not accepted, byte_ready=%b", b, byte_ready);
        break;
      end
    end
    byte_valid = 1'b0;
    if (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_end(input string name, input bit want_err);
    int n;
    n = 0;
    while (!(want_err ? load_err : load_done) && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, 64'({load_done, load_err, core_rst}), want_err ? 64'b011 : 64'b100);
  endtask

  task automatic check_t1_writes(input string name);
    check({name, "_count"}, 64'(wl_addr.size()), 64'd2);
    if (wl_addr.size() >= 2) begin
      check({name, "_w0"}, 64'({wl_addr[0], wl_data[0]}), 64'({ADDR_W'(BASE_ADDR), 32'h12345678}));
      check({name, "_w1"}, 64'({wl_addr[1], wl_data[1]}), 64'({ADDR_W'(BASE_ADDR + 1), 32'hDEADBEEF}));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b1;
    byte_valid = 1'b0;
    byte_data  = 8'h00;

    img = '{8'h02, 8'h00, 8'h00, 8'h00,
            8'h78, 8'h56, 8'h34, 8'h12,
            8'hEF, 8'hBE, 8'hAD, 8'hDE};
    img_sum = 8'h00;
    for (int unsigned i = 4; i < 12; i++) img_sum = img_sum + img[i];

    // ---- T1: two-word load, valid every cycle ----
    add(1, 0, 8'h00, 0, 0, 0, 32'h0,        1, 0, 0);
    add(0, 0, 8'h00, 1, 0, 0, 32'h0,        1, 0, 0);
    add(0, 1, 8'h02, 1, 0, 0, 32'h0,        1, 0, 0);
    add(0, 1, 8'h00, 1, 0, 0, 32'h0,        1, 0, 0);
    add(0, 1, 8'h00, 1, 0, 0, 32'h0,        1, 0, 0);
    add(0, 1, 8'h00, 1, 0, 0, 32'h0,        1, 0, 0);
    add(0, 1, 8'h78, 1, 0, 0, 32'h0,        1, 0, 0);
    add(0, 1, 8'h56, 1, 0, 0, 32'h0,        1, 0, 0);
    add(0, 1, 8'h34, 1, 0, 0, 32'h0,        1, 0, 0);
    add(0, 1, 8'h12, 0, 1, 0, 32'h12345678, 1, 0, 0);
    add(0, 1, 8'hEF, 1, 0, 0, 32'h12345678, 1, 0, 0);  // not taken: WRITE cycle
    add(0, 1, 8'hEF, 1, 0, 0, 32'h12345678, 1, 0, 0);
    add(0, 1, 8'hBE, 1, 0, 0, 32'h12345678, 1, 0, 0);
    add(0, 1, 8'hAD, 1, 0, 0, 32'h12345678, 1, 0, 0);
    add(0, 1, 8'hDE, 0, 1, 1, 32'hDEADBEEF, 1, 0, 0);
`ifdef CHECKSUM_EN
    add(0, 0, 8'h00, 1, 0, 1, 32'hDEADBEEF, 1, 0, 0);
    add(0, 1, 8'h4C, 0, 0, 1, 32'hDEADBEEF, 0, 1, 0);
`else
    add(0, 0, 8'h00, 0, 0, 1, 32'hDEADBEEF, 0, 1, 0);
`endif
    add(0, 1, 8'h55, 0, 0, 1, 32'hDEADBEEF, 0, 1, 0);

    // ---- T2: empty image ----
    add(1, 0, 8'h00, 0, 0, 0, 32'h0, 1, 0, 0);
    add(0, 0, 8'h00, 1, 0, 0, 32'h0, 1, 0, 0);
    add(0, 1, 8'h00, 1, 0, 0, 32'h0, 1, 0, 0);
    add(0, 1, 8'h00, 1, 0, 0, 32'h0, 1, 0, 0);
    add(0, 1, 8'h00, 1, 0, 0, 32'h0, 1, 0, 0);
`ifdef CHECKSUM_EN
    add(0, 1, 8'h00, 1, 0, 0, 32'h0, 1, 0, 0);
    add(0, 1, 8'h00, 0, 0, 0, 32'h0, 0, 1, 0);
`else
    add(0, 1, 8'h00, 0, 0, 0, 32'h0, 0, 1, 0);
`endif
    add(0, 1, 8'h11, 0, 0, 0, 32'h0, 0, 1, 0);

    // ---- T3: oversize N = DEPTH+1 ----
    add(1, 0, 8'h00, 0, 0, 0, 32'h0, 1, 0, 0);
    add(0, 0, 8'h00, 1, 0, 0, 32'h0, 1, 0, 0);
    add(0, 1, (DEPTH + 1) & 255,         1, 0, 0, 32'h0, 1, 0, 0);
    add(0, 1, ((DEPTH + 1) >> 8) & 255,  1, 0, 0, 32'h0, 1, 0, 0);
    add(0, 1, ((DEPTH + 1) >> 16) & 255, 1, 0, 0, 32'h0, 1, 0, 0);
    add(0, 1, ((DEPTH + 1) >> 24) & 255, 0, 0, 0, 32'h0, 1, 0, 1);
    add(0, 1, 8'hAA, 0, 0, 0, 32'h0, 1, 0, 1);
    add(0, 1, 8'hAA, 0, 0, 0, 32'h0, 1, 0, 1);

    // ---- N = DEPTH exactly is accepted ----
    add(1, 0, 8'h00, 0, 0, 0, 32'h0, 1, 0, 0);
    add(0, 0, 8'h00, 1, 0, 0, 32'h0, 1, 0, 0);
    add(0, 1, DEPTH & 255,         1, 0, 0, 32'h0, 1, 0, 0);
    add(0, 1, (DEPTH >> 8) & 255,  1, 0, 0, 32'h0, 1, 0, 0);
    add(0, 1, (DEPTH >> 16) & 255, 1, 0, 0, 32'h0, 1, 0, 0);
    add(0, 1, (DEPTH >> 24) & 255, 1, 0, 0, 32'h0, 1, 0, 0);

    foreach (tbl[i]) begin
      rst_n      = tbl[i].rst;
      byte_valid = tbl[i].v;
      byte_data  = tbl[i].d;
      @(posedge clk);
      #1;
      check($sformatf("row%0d", i), obs(),
            64'({tbl[i].rdy, tbl[i].we, tbl[i].a, tbl[i].wd, tbl[i].crst, tbl[i].dn, tbl[i].er}));
    end

    // ---- T4: byte_valid gaps, plus a long stall inside word 0 ----
    do_reset();
    wl_addr.delete();
    wl_data.delete();
    for (int unsigned i = 0; i < 6; i++) send_byte(img[i], 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("t4_partial_no_write", 64'(wl_addr.size()), 64'd0);
    check("t4_partial_ready", 64'({byte_ready, load_done, core_rst}), 64'b101);
    for (int unsigned i = 6; i < 12; i++) send_byte(img[i], 1'b1);
`ifdef CHECKSUM_EN
    send_byte(img_sum, 1'b1);
`endif
    wait_end("t4_done", 1'b0);
    check_t1_writes("t4");

    // ---- T5: reset after two data bytes, then full reload ----
    do_reset();
    wl_addr.delete();
    wl_data.delete();
    for (int unsigned i = 0; i < 6; i++) send_byte(img[i], 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("t5_reset_values", obs(),
          64'({1'b0, 1'b0, ADDR_W'(BASE_ADDR), 32'h0, 1'b1, 1'b0, 1'b0}));
    rst_n = 1'b0;
    check("t5_no_stray_write", 64'(wl_addr.size()), 64'd0);
    for (int unsigned i = 0; i < 12; i++) send_byte(img[i], 1'b0);
`ifdef CHECKSUM_EN
    send_byte(img_sum, 1'b0);
`endif
    wait_end("t5_done", 1'b0);
    check_t1_writes("t5");

`ifdef CHECKSUM_EN
    // ---- T6: checksum match and mismatch ----
    do_reset();
    for (int unsigned i = 0; i < 12; i++) send_byte(img[i], 1'b0);
    send_byte(8'h4C, 1'b0);
    wait_end("t6_match", 1'b0);
    do_reset();
    for (int unsigned i = 0; i < 12; i++) send_byte(img[i], 1'b0);
    send_byte(8'h4D, 1'b0);
    wait_end("t6_mismatch", 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
